// File: rtl/zbus_master_if.sv
// ZX-bus signal bundle between the host-side initiator and a peripheral card.
//   master : drives address, data-out/enable, strobes, refresh and bus reset;
//            samples data-in and the card's ziorqge response.
//   slave  : the card side of the same wires.
interface zbus_master_if;
  logic [15:0] za;
  logic [7:0]  zd_out;
  logic        zd_oe;
  logic [7:0]  zd_in;
  logic        ziorq_n;
  logic        zmreq_n;
  logic        zrd_n;
  logic        zwr_n;
  logic        zrfsh_n;
  logic        zrst_n;
  logic        ziorqge;

  modport master (
    output za, zd_out, zd_oe, ziorq_n, zmreq_n, zrd_n, zwr_n, zrfsh_n, zrst_n,
    input  zd_in, ziorqge
  );

  modport slave (
    input  za, zd_out, zd_oe, ziorq_n, zmreq_n, zrd_n, zwr_n, zrfsh_n, zrst_n,
    output zd_in, ziorqge
  );
endinterface

// File: rtl/zbus_master.sv
// Z80-style ZX-bus initiator. Runs one I/O or memory read/write cycle at a time
// with T1/T2/(TW)/T3 sequencing, holds the card in bus reset after power-up,
// and returns read data plus the sampled ziorqge response.
//
// Ports:
//   clk, rst_n          : single clock, asynchronous active-low reset
//   req / ready         : request handshake, accepted only in IDLE (ready=1)
//   write, mem          : cycle kind, latched on accept
//   addr, wrdata        : cycle address / write data, latched on accept
//   done                : one-clock pulse on the first IDLE clock after T3
//   rddata, ge_seen     : values captured at the end of T3
//   bus (master)        : ZX-bus address, data, strobes, refresh, bus reset
module zbus_master #(
  parameter int TCLK    = 2,   // clocks per T-state
  parameter int IO_WAIT = 1,   // automatic wait states in I/O cycles (0..3)
  parameter int RST_T   = 16   // T-states of bus reset after rst_n release
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  output logic        ready,
  input  logic        write,
  input  logic        mem,
  input  logic [15:0] addr,
  input  logic [7:0]  wrdata,
  output logic        done,
  output logic [7:0]  rddata,
  output logic        ge_seen,
  zbus_master_if.master bus
);

  localparam int TICK_W = (TCLK > 1) ? $clog2(TCLK) : 1;
  localparam int RST_W  = (RST_T > 1) ? $clog2(RST_T) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TCLK - 1);
  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_T - 1);
  // With IO_WAIT=0 the TW state is never entered, so this value is unused.
  localparam logic [1:0]        WAIT_LAST = 2'(IO_WAIT - 1);
  localparam bit                HAS_WAIT  = (IO_WAIT > 0);

  typedef enum logic [2:0] {
    BRST = 3'd0,
    IDLE = 3'd1,
    T1   = 3'd2,
    T2   = 3'd3,
    TW   = 3'd4,
    T3   = 3'd5
  } state_t;

  state_t            state_r;
  logic [TICK_W-1:0] tick_r;
  logic [RST_W-1:0]  rst_cnt_r;
  logic [1:0]        wait_cnt_r;
  logic              write_r;
  logic              mem_r;
  logic              tend_s;

  // End of the current T-state.
  assign tend_s = (tick_r == TICK_LAST);

  // Refresh is never issued by this initiator.
  assign bus.zrfsh_n = 1'b1;

  // Cycle sequencer; every output is registered and set on state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= BRST;
      tick_r      <= '0;
      rst_cnt_r   <= '0;
      wait_cnt_r  <= 2'd0;
      write_r     <= 1'b0;
      mem_r       <= 1'b0;
      ready       <= 1'b0;
      done        <= 1'b0;
      rddata      <= 8'h00;
      ge_seen     <= 1'b0;
      bus.za      <= 16'hFFFF;
      bus.zd_out  <= 8'h00;
      bus.zd_oe   <= 1'b0;
      bus.ziorq_n <= 1'b1;
      bus.zmreq_n <= 1'b1;
      bus.zrd_n   <= 1'b1;
      bus.zwr_n   <= 1'b1;
      bus.zrst_n  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        BRST: begin
          if (tend_s) begin
            tick_r <= '0;
            if (rst_cnt_r == RST_LAST) begin
              rst_cnt_r  <= '0;
              state_r    <= IDLE;
              bus.zrst_n <= 1'b1;
              ready      <= 1'b1;
            end else begin
              rst_cnt_r <= rst_cnt_r + RST_W'(1);
            end
          end else begin
            tick_r <= tick_r + TICK_W'(1);
          end
        end

        IDLE: begin
          tick_r <= '0;
          if (req) begin
            write_r    <= write;
            mem_r      <= mem;
            bus.za     <= addr;
            bus.zd_out <= wrdata;
            bus.zd_oe  <= write;
            ready      <= 1'b0;
            state_r    <= T1;
          end else begin
            ready <= 1'b1;
          end
        end

        T1: begin
          if (tend_s) begin
            tick_r      <= '0;
            state_r     <= T2;
            // Exactly one of iorq/mreq, and exactly one of rd/wr.
            bus.ziorq_n <= mem_r;
            bus.zmreq_n <= ~mem_r;
            bus.zrd_n   <= write_r;
            bus.zwr_n   <= ~write_r;
          end else begin
            tick_r <= tick_r + TICK_W'(1);
          end
        end

        T2: begin
          if (tend_s) begin
            tick_r     <= '0;
            wait_cnt_r <= 2'd0;
            if (!mem_r && HAS_WAIT) begin
              state_r <= TW;
            end else begin
              state_r <= T3;
            end
          end else begin
            tick_r <= tick_r + TICK_W'(1);
          end
        end

        TW: begin
          if (tend_s) begin
            tick_r <= '0;
            if (wait_cnt_r == WAIT_LAST) begin
              state_r <= T3;
            end else begin
              wait_cnt_r <= wait_cnt_r + 2'd1;
            end
          end else begin
            tick_r <= tick_r + TICK_W'(1);
          end
        end

        T3: begin
          if (tend_s) begin
            tick_r      <= '0;
            state_r     <= IDLE;
            ready       <= 1'b1;
            done        <= 1'b1;
            bus.ziorq_n <= 1'b1;
            bus.zmreq_n <= 1'b1;
            bus.zrd_n   <= 1'b1;
            bus.zwr_n   <= 1'b1;
            bus.zd_oe   <= 1'b0;
            // Writes leave the last read data alone but still report ge.
            if (!write_r) begin
              rddata <= bus.zd_in;
            end else begin
              rddata <= rddata;
            end
            ge_seen <= mem_r ? 1'b0 : bus.ziorqge;
          end else begin
            tick_r <= tick_r + TICK_W'(1);
          end
        end

        default: begin
          // Unreachable encodings recover through a full bus reset.
          state_r     <= BRST;
          tick_r      <= '0;
          rst_cnt_r   <= '0;
          ready       <= 1'b0;
          bus.zrst_n  <= 1'b0;
          bus.ziorq_n <= 1'b1;
          bus.zmreq_n <= 1'b1;
          bus.zrd_n   <= 1'b1;
          bus.zwr_n   <= 1'b1;
          bus.zd_oe   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/zbus_master.md
Name: zbus_master

Overview:
- Z80-style ZX-bus initiator. It generates I/O and memory read/write cycles, with Z80 T-state sequencing, toward a ZX-bus peripheral card.
- Used in the host-side FPGA fixture to drive the card's bus slave: za/zd, the strobes, and bus reset.
- It also samples the card's ziorqge response.
- It accepts one cycle request at a time over a req/ready handshake and returns read data with a one-clock done pulse.

Parameters:
TCLK, 2, clocks per T-state (>=1)
IO_WAIT, 1, automatic TW states inserted in I/O cycles (0..3; Z80 = 1)
RST_T, 16, T-states zrst_n is held low after rst_n release (>=1)

Ports:
clk  in  1  system clock; single clock domain
rst_n  in  1  asynchronous, active-low reset
req  in  1  cycle request, sampled only when ready=1
ready  out  1  high in IDLE only
write  in  1  1=write cycle, 0=read cycle (latched on accept)
mem  in  1  1=memory cycle, 0=I/O cycle (latched on accept)
addr  in  16  cycle address (latched on accept)
wrdata  in  8  write data (latched on accept)
done  out  1  one-clock pulse at cycle completion
rddata  out  8  read data, valid from done onward until next done
ge_seen  out  1  ziorqge sampled at end of T3 (I/O cycles only, else 0)
za  out  16  bus address
zd_out  out  8  bus data out
zd_oe  out  1  bus data output enable
zd_in  in  8  bus data in
ziorq_n  out  1  I/O request strobe
zmreq_n  out  1  memory request strobe
zrd_n  out  1  read strobe
zwr_n  out  1  write strobe
zrfsh_n  out  1  refresh; constant 1
zrst_n  out  1  bus reset
ziorqge  in  1  card I/O-response indication

Behaviour:
- Reset values:
  - ziorq_n, zmreq_n, zrd_n, zwr_n, zrfsh_n = 1
  - zd_oe = 0, zd_out = 0, za = 16'hFFFF
  - zrst_n = 0, ready = 0, done = 0, rddata = 0, ge_seen = 0
  - state = BRST
- T-state timing:
  - A tick counter runs 0..TCLK-1 in every non-IDLE state and is cleared on each state change.
  - The last count marks the end of a T-state (tend).
- States: BRST, IDLE, T1, T2, TW, T3.
- BRST:
  - zrst_n = 0 for RST_T T-states (RST_T*TCLK clocks), then go to IDLE.
  - zrst_n = 1 from the first IDLE clock onward.
- IDLE:
  - ready = 1.
  - On the clock with req=1: latch addr, wrdata, write, mem; enter T1 on the next clock.
- T1 -> T2 -> (TW x IO_WAIT, I/O cycles only) -> T3 -> IDLE, each transition on tend.
- za = latched address from T1 through T3. It holds its last value in IDLE.
- Strobes, asserted low from the first clock of T2 through the last clock of T3, TW included:
  - I/O cycle: ziorq_n, plus zrd_n or zwr_n.
  - Memory cycle: zmreq_n, plus zrd_n or zwr_n.
  - zmreq_n and ziorq_n are never low together.
  - No strobe is low in T1 or IDLE.
- Write cycle: zd_out = latched wrdata and zd_oe = 1 from T1 through T3. zd_oe = 0 in reads and in IDLE.
- Read capture: on the clock T3 ends, capture rddata <= zd_in, and ge_seen <= ziorqge for I/O cycles, 0 for memory cycles.
  - rddata is unchanged by write cycles.
  - ge_seen is also updated on write cycles.
- Completion:
  - done = 1 on the first IDLE clock after T3 (ready=1 on that same clock).
  - Cycle length from the first T1 clock to the done clock: I/O (3+IO_WAIT)*TCLK clocks; memory 3*TCLK clocks.
- Back-to-back: req=1 on the done clock is accepted; the next T1 starts the following clock. Strobes are therefore high for at least one full T-state (T1) between cycles.
- req and the other request inputs are ignored outside IDLE. Changes to addr/wrdata mid-cycle have no effect.
- rst_n asserted at any point (including mid-cycle):
  - All outputs take their reset values immediately (asynchronously).
  - No done pulse is generated.
  - After release the full BRST sequence repeats.
- TCLK=1: every state lasts exactly one clock; the same rules apply.

Test Plan:
1. Reset (TCLK=2, RST_T=16): release rst_n -> zrst_n low exactly 32 clocks; ready rises on the same clock zrst_n goes 1; all strobes 1 throughout.
2. I/O write, addr=16'h00AB, wrdata=8'h5A, IO_WAIT=1 -> za=00AB and zd_oe=1 for 8 clocks from T1; ziorq_n and zwr_n low for 6 clocks; zmreq_n=1; done on clock 8 after T1 start.
3. I/O read, addr=16'h83AB, bench zd_in=8'hC3, ziorqge=1 -> zrd_n/ziorq_n low 6 clocks; zd_oe=0; rddata=C3; ge_seen=1 at done.
4. Memory read, addr=16'h0000, zd_in=8'h3E -> zmreq_n/zrd_n low 4 clocks; ziorq_n stays 1; rddata=3E; ge_seen=0; done 6 clocks after T1 start.
5. Back-to-back: req held high through a memory write then an I/O read -> second T1 starts the clock after done; strobes high >=2 clocks between cycles; exactly two done pulses.
6. rst_n asserted during TW of an I/O read -> strobes 1 and zd_oe 0 immediately; zrst_n=0; no done pulse; after release a 32-clock BRST, then ready=1.
